hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage CPU. It decides every cycle whether each pipeline register advances, holds, bubbles or flushes. It covers load-use hazards the forwarding unit cannot resolve, taken-branch flushes, and multi-cycle data-memory waits, with a timeout watchdog. It sits beside the forwarding unit, reads ID/EX/MEM stage fields, and drives the PC and pipeline-register enables.

## Interface
- TIMEOUT, 64: max cycles a data-memory access may wait before an error is declared (≥2).
- CNT_W, 16: width of the performance counters.

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- IFIDRs, IFIDRt  in  5 each  source registers of the instruction in ID.
- IFIDUsesRt  in  1  ID instruction reads Rt as a source (R-type, store, branch).
- IDEXRt  in  5  destination register of the instruction in EX.
- IDEXMemRead  in  1  EX instruction is a load.
- BranchTaken  in  1  EX resolved a taken branch or jump.
- DmemReq  in  1  MEM stage has an active load or store.
- DmemReady  in  1  data memory completes the access this cycle.
- PCWrite, IFIDWrite  out  1 each  enables for PC and IF/ID.
- IDEXBubble  out  1  zero the control fields written into ID/EX.
- IFIDFlush, IDEXFlush  out  1 each  clear IF/ID and ID/EX to NOP.
- PipeFreeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- MemTimeout  out  1  sticky error flag.
- StallCycles, FlushCount  out  CNT_W each  saturating performance counters.

## Operation
- States: RUN, MEM_WAIT, ERROR. Control outputs are combinational from the current state and inputs. State, the wait counter and the performance counters are registered.
- Definitions:
  - memwait = DmemReq && !DmemReady.
  - loaduse = IDEXMemRead && IDEXRt≠0 && (IDEXRt==IFIDRs || (IFIDUsesRt && IDEXRt==IFIDRt)).
- Priority in RUN and MEM_WAIT, highest first:
  1. **freeze** (memwait): PCWrite=0, IFIDWrite=0, PipeFreeze=1. All flush and bubble outputs are 0.
  2. **branch** (BranchTaken): PCWrite=1, IFIDFlush=1, IDEXFlush=1. This takes priority over loaduse, because the loading instruction's consumer is squashed.
  3. **load-use** (loaduse): PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  4. **default**: PCWrite=1, IFIDWrite=1, all others 0.
- Transitions:
  - RUN → MEM_WAIT on memwait. The wait counter is loaded with 1.
  - MEM_WAIT stays on memwait and the wait counter increments. If memwait holds with wait counter == TIMEOUT-1, go to ERROR.
  - MEM_WAIT → RUN when DmemReady=1. In that cycle the freeze is released and rows 2–4 are evaluated normally.
  - ERROR is absorbing: PCWrite=0, IFIDWrite=0, PipeFreeze=1, MemTimeout=1 until reset.
- Counters:
  - StallCycles increments on every cycle with row 1 or row 3 active, or in ERROR.
  - FlushCount increments on every cycle with row 2 active.
  - Both saturate at 2^CNT_W−1 and never wrap.
- DmemReq is held stable by the frozen EX/MEM register. Dropping DmemReq in MEM_WAIT counts as completion (→ RUN).

## Timing
- Reset (rst_n low at a rising edge):
  - state=RUN, wait counter=0, MemTimeout=0, StallCycles=0, FlushCount=0.
  - With idle inputs, outputs then read PCWrite=1, IFIDWrite=1, all others 0.
- Reset mid-wait or in ERROR returns to RUN on that edge.
- Latency:
  - Hazard responses are same-cycle (zero latency).
  - A load-use stall lasts exactly one cycle: the bubble clears IDEXMemRead.
  - A branch flush lasts one cycle.
- A memory wait of N cycles with DmemReady low freezes for exactly N cycles. DmemReady high in the request cycle gives zero freeze.
- Timeout: ERROR is entered on the edge ending the TIMEOUT-th consecutive memwait cycle. MemTimeout is visible the following cycle.
- Simultaneous events: memwait masks branch and load-use. Those are re-evaluated, not lost, once the freeze releases.

## Structure
- The shared CPU package holds:
  - the state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - the register-zero constant (5'd0);
  - defaults for TIMEOUT and CNT_W.
- The sub-module `sat_counter` (parameter W; inc, clear, value) is instantiated twice, for StallCycles and FlushCount.
- Load-use compare logic stays inline.

## Test plan
- IDEXMemRead=1, IDEXRt=8, IFIDRs=8 → one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1. Next cycle (IDEXMemRead=0) returns to default. StallCycles=1.
- IDEXRt=0 with IDEXMemRead=1 and IFIDRs=0 → no stall. Also IDEXRt=9, IFIDRt=9, IFIDUsesRt=0 → no stall.
- BranchTaken=1 together with loaduse → IFIDFlush=IDEXFlush=1, IDEXBubble=0, PCWrite=1. FlushCount increments by 1.
- DmemReq=1 with DmemReady low for 3 cycles, then high with BranchTaken=1 → PipeFreeze=1 for 3 cycles, then flush in the ready cycle. StallCycles=3.
- TIMEOUT=4, DmemReady held low → ERROR after 4 cycles, MemTimeout=1 sticky. rst_n low for one edge → all counters 0, state RUN.
- CNT_W=4: 20 consecutive stalls → StallCycles saturates at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
// Shared definitions for the pipeline sequencing controller: controller
// state encoding, the register-zero constant and parameter defaults.
// No ports.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk    in  1  clock, rising edge
//   clear  in  1  synchronous clear (wins over inc)
//   inc    in  1  count this cycle
//   value  out W  current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage CPU. Each cycle it decides
// whether PC and pipeline registers advance, hold, bubble or flush, covering
// load-use hazards, taken-branch flushes and data-memory waits, with a
// watchdog that latches an error if a memory access never completes.
// Ports:
//   clk, rst_n            clock / synchronous active-low reset
//   IFIDRs, IFIDRt        ID source registers; IFIDUsesRt: ID reads Rt
//   IDEXRt, IDEXMemRead   EX destination register / EX is a load
//   BranchTaken           EX resolved a taken branch or jump
//   DmemReq, DmemReady    MEM access active / completes this cycle
//   PCWrite, IFIDWrite    PC and IF/ID enables
//   IDEXBubble            zero control fields into ID/EX
//   IFIDFlush, IDEXFlush  clear IF/ID, ID/EX to NOP
//   PipeFreeze            hold ID/EX, EX/MEM, MEM/WB
//   MemTimeout            sticky memory-timeout error
//   StallCycles, FlushCount  saturating performance counters
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFIDUsesRt,
    input  logic [4:0]       IDEXRt,
    input  logic             IDEXMemRead,
    input  logic             BranchTaken,
    input  logic             DmemReq,
    input  logic             DmemReady,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             PipeFreeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT) + 1;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wait_cnt;

    logic w_memwait;
    logic w_loaduse;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_memwait = DmemReq && !DmemReady;
    assign w_loaduse = IDEXMemRead && (IDEXRt != REG_ZERO) &&
                       ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));

    // Priority: freeze > branch flush > load-use bubble > advance.
    // A branch outranks load-use because the dependent instruction is squashed.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        PipeFreeze  = 1'b0;
        MemTimeout  = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (r_state == ST_ERROR) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            PipeFreeze  = 1'b1;
            MemTimeout  = 1'b1;
            w_stall_inc = 1'b1;
        end else if (w_memwait) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            PipeFreeze  = 1'b1;
            w_stall_inc = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_loaduse) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXBubble  = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    // Wait counter holds the number of memwait cycles already completed, so
    // reaching TIMEOUT-1 while still waiting marks the TIMEOUT-th cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_memwait) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WCNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_memwait) begin
                        if (r_wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                            r_state <= ST_ERROR;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (w_stall_inc),
        .value (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (w_flush_inc),
        .value (FlushCount)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    // Control vector bit order:
    // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze, MemTimeout}
    localparam logic [6:0] DEF = 7'b1100000;
    localparam logic [6:0] LU  = 7'b0010000;
    localparam logic [6:0] BR  = 7'b1101100;
    localparam logic [6:0] FRZ = 7'b0000010;
    localparam logic [6:0] ERR = 7'b0000011;
    localparam logic [6:0] ALL = 7'b1111111;
    localparam logic [6:0] BRC = 7'b1011111; // IFIDWrite left open during a flush

    typedef struct packed {
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [6:0] val;
        logic [6:0] care;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       IFIDRs = '0, IFIDRt = '0, IDEXRt = '0;
    logic             IFIDUsesRt = 1'b0, IDEXMemRead = 1'b0, BranchTaken = 1'b0;
    logic             DmemReq = 1'b0, DmemReady = 1'b0;
    logic             PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush;
    logic             PipeFreeze, MemTimeout;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IFIDRs      (IFIDRs),
        .IFIDRt      (IFIDRt),
        .IFIDUsesRt  (IFIDUsesRt),
        .IDEXRt      (IDEXRt),
        .IDEXMemRead (IDEXMemRead),
        .BranchTaken (BranchTaken),
        .DmemReq     (DmemReq),
        .DmemReady   (DmemReady),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IDEXBubble  (IDEXBubble),
        .IFIDFlush   (IFIDFlush),
        .IDEXFlush   (IDEXFlush),
        .PipeFreeze  (PipeFreeze),
        .MemTimeout  (MemTimeout),
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic mr, input logic [4:0] ex_rt,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses, input logic br,
                                 input logic req, input logic rdy);
        stim_t s;
        s = '{mr: mr, ex_rt: ex_rt, rs: rs, rt: rt, uses: uses, br: br, req: req, rdy: rdy};
        return s;
    endfunction

    function automatic logic [6:0] obs_vec();
        return {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, PipeFreeze, MemTimeout};
    endfunction

    // Drive one cycle of stimulus just after the edge and queue its expected controls.
    task automatic apply(input stim_t s, input logic [6:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        IDEXMemRead = s.mr;
        IDEXRt      = s.ex_rt;
        IFIDRs      = s.rs;
        IFIDRt      = s.rt;
        IFIDUsesRt  = s.uses;
        BranchTaken = s.br;
        DmemReq     = s.req;
        DmemReady   = s.rdy;
        e.val  = v;
        e.care = (v == BR) ? BRC : ALL;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        {IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt, BranchTaken, DmemReq, DmemReady} = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        // Enter a wait, then reset in the middle of it.
        s = '{mk(0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,1,0)};
        v = '{FRZ, FRZ};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL reset_prewait[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        do_reset();
        apply(mk(0,0,0,0,0,0,0,0), DEF);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ((obs_vec() & e.care) !== (e.val & e.care)) begin
            errors++;
            $display("FAIL reset_idle ctrl got=%b want=%b", obs_vec(), e.val);
        end
        checks++;
        if (StallCycles !== 4'd0 || FlushCount !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters stall=%0d flush=%0d want 0/0", StallCycles, FlushCount);
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        s = '{mk(1,8,8,0,0,0,0,0), mk(0,8,8,0,0,0,0,0),
              mk(1,9,3,9,1,0,0,0), mk(0,0,0,0,0,0,0,0)};
        v = '{LU, DEF, LU, DEF};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL load_use[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (StallCycles !== 4'd2) begin
            errors++;
            $display("FAIL load_use_stall_count got=%0d want=2", StallCycles);
        end
    endtask

    task automatic test_no_stall();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        s = '{mk(1,0,0,0,1,0,0,0), mk(1,9,3,9,0,0,0,0),
              mk(0,8,8,8,1,0,0,0), mk(1,7,3,4,1,0,0,0)};
        v = '{DEF, DEF, DEF, DEF};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL no_stall[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (StallCycles !== 4'd0) begin
            errors++;
            $display("FAIL no_stall_count got=%0d want=0", StallCycles);
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        s = '{mk(1,8,8,0,0,1,0,0), mk(0,0,0,0,0,0,0,0)};
        v = '{BR, DEF};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL branch[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (FlushCount !== 4'd1 || StallCycles !== 4'd0) begin
            errors++;
            $display("FAIL branch_counts flush=%0d stall=%0d want 1/0", FlushCount, StallCycles);
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        // Freeze masks a pending branch and load-use; the branch wins on release.
        s = '{mk(1,8,8,0,0,1,1,0), mk(1,8,8,0,0,1,1,0), mk(1,8,8,0,0,1,1,0),
              mk(0,0,0,0,0,1,1,1), mk(0,0,0,0,0,0,0,0)};
        v = '{FRZ, FRZ, FRZ, BR, DEF};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL mem_wait[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (StallCycles !== 4'd3 || FlushCount !== 4'd1) begin
            errors++;
            $display("FAIL mem_wait_counts stall=%0d flush=%0d want 3/1", StallCycles, FlushCount);
        end
        do_reset();
        // Ready in request cycle, dropped request, and load-use surviving a freeze.
        s = '{mk(0,0,0,0,0,0,1,1), mk(0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0),
              mk(1,5,5,0,0,0,1,0), mk(1,5,5,0,0,0,1,1), mk(0,0,0,0,0,0,0,0)};
        v = '{DEF, FRZ, DEF, FRZ, LU, DEF};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL mem_release[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (StallCycles !== 4'd3) begin
            errors++;
            $display("FAIL mem_release_count got=%0d want=3", StallCycles);
        end
    endtask

    task automatic test_timeout();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        s = '{mk(0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,1,0),
              mk(0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,0), mk(0,0,0,0,0,1,1,1),
              mk(1,8,8,0,0,0,0,0)};
        v = '{FRZ, FRZ, FRZ, FRZ, ERR, ERR, ERR};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL timeout[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (StallCycles !== 4'd6 || FlushCount !== 4'd0) begin
            errors++;
            $display("FAIL timeout_counts stall=%0d flush=%0d want 6/0", StallCycles, FlushCount);
        end
        do_reset();
        apply(mk(0,0,0,0,0,0,0,0), DEF);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ((obs_vec() & e.care) !== (e.val & e.care)) begin
            errors++;
            $display("FAIL timeout_reset ctrl got=%b want=%b", obs_vec(), e.val);
        end
        checks++;
        if (StallCycles !== 4'd0 || FlushCount !== 4'd0) begin
            errors++;
            $display("FAIL timeout_reset_counts stall=%0d flush=%0d want 0/0", StallCycles, FlushCount);
        end
    endtask

    task automatic test_saturation();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        for (int unsigned blk = 0; blk < 2; blk++) begin
            s.delete();
            v.delete();
            for (int i = 0; i < ((blk == 0) ? 15 : 5); i++) begin
                s.push_back(mk(1,8,8,0,0,0,0,0));
                v.push_back(LU);
            end
            s.push_back(mk(0,0,0,0,0,0,0,0));
            v.push_back(DEF);
            for (int i = 0; i < s.size(); i++) begin
                apply(s[i], v[i]);
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                    errors++;
                    $display("FAIL saturation[%0d.%0d] ctrl got=%b want=%b", blk, i, obs_vec(), e.val);
                end
            end
            checks++;
            if (StallCycles !== 4'd15) begin
                errors++;
                $display("FAIL saturation_count[%0d] got=%0d want=15", blk, StallCycles);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [6:0] v[$];
        exp_t e;
        do_reset();
        s = '{mk(0,0,0,0,0,1,0,0), mk(0,0,0,0,0,1,0,0), mk(1,8,8,0,0,0,0,0),
              mk(1,8,8,0,0,1,0,0), mk(1,9,0,9,1,0,0,0), mk(0,0,0,0,0,1,0,0),
              mk(0,0,0,0,0,0,0,0)};
        v = '{BR, BR, LU, BR, LU, BR, DEF};
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], v[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ((obs_vec() & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL back_to_back[%0d] ctrl got=%b want=%b", i, obs_vec(), e.val);
            end
        end
        checks++;
        if (FlushCount !== 4'd4 || StallCycles !== 4'd2) begin
            errors++;
            $display("FAIL back_to_back_counts flush=%0d stall=%0d want 4/2", FlushCount, StallCycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
